// File: rtl/puf_auth_pkg.sv
// Shared types and constants for the PUF authentication verifier.
package puf_auth_pkg;

    localparam int         RESP_W      = 128;
    localparam int         CHUNK_W_DEF = 16;
    localparam int         NUM_CHUNKS  = RESP_W / CHUNK_W_DEF;
    localparam int         TIMEOUT_DEF = 1023;
    localparam logic [7:0] HD_TIMEOUT  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        RESTART,
        WAIT,
        COMPARE,
        DECIDE,
        DONE
    } state_t;

endpackage

// File: rtl/puf_auth_verifier_popcount.sv
// Combinational population count of one comparison chunk.
module popcount_chunk #(
    parameter int CHUNK_W = 16
) (
    input  logic [CHUNK_W-1:0]       bits,
    output logic [$clog2(CHUNK_W):0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            count = count + {{$clog2(CHUNK_W){1'b0}}, bits[i]};
        end
    end

endmodule

// File: rtl/puf_auth_verifier.sv
// Restarts a PUF generator, captures its response and checks Hamming distance to a reference.
// done rises 10 edges after the capturing edge (default CHUNK_W); start ignored while busy.
module puf_auth_verifier
    import puf_auth_pkg::*;
#(
    parameter int CHUNK_W = CHUNK_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ref_resp,
    input  logic [7:0]   threshold,
    input  logic [127:0] puf_resp,
    input  logic         puf_done,
    output logic         puf_rst,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         timeout,
    output logic [7:0]   hd
);

    localparam int NCH   = RESP_W / CHUNK_W;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int PC_W  = $clog2(CHUNK_W) + 1;

    state_t              state_q, state_d;
    logic                rst_cnt;
    logic [CNT_W-1:0]    wait_cnt;
    logic [IDX_W-1:0]    idx;
    logic [7:0]          acc;
    logic [7:0]          thr_q;
    logic [RESP_W-1:0]   cap_q;
    logic [RESP_W-1:0]   ref_q;
    logic [PC_W-1:0]     pc;
    logic                accept;
    logic                capture;
    logic                expire;

    // Both words shift left each COMPARE cycle, so the top chunk is always the one under test.
    popcount_chunk #(.CHUNK_W(CHUNK_W)) u_popcount (
        .bits  (cap_q[RESP_W-1 -: CHUNK_W] ^ ref_q[RESP_W-1 -: CHUNK_W]),
        .count (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        puf_rst = 1'b1;
        accept  = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RESTART;
                end
            end
            RESTART: begin
                if (rst_cnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                puf_rst = 1'b0;
                // A flag left over from the previous run is ignored on the first WAIT cycle.
                if (wait_cnt != '0 && puf_done) begin
                    capture = 1'b1;
                    state_d = COMPARE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    expire  = 1'b1;
                    state_d = DONE;
                end
            end
            COMPARE: begin
                puf_rst = 1'b0;
                if (idx == IDX_W'(NCH - 1)) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                puf_rst = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt  <= 1'b0;
            wait_cnt <= '0;
            idx      <= '0;
            acc      <= '0;
            thr_q    <= '0;
            cap_q    <= '0;
            ref_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            hd       <= '0;
        end else begin
            if (accept) begin
                ref_q    <= ref_resp;
                thr_q    <= threshold;
                rst_cnt  <= 1'b0;
                wait_cnt <= '0;
                busy     <= 1'b1;
                done     <= 1'b0;
                pass     <= 1'b0;
                timeout  <= 1'b0;
                hd       <= '0;
            end else if (state_q == DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
            if (state_q == RESTART) begin
                rst_cnt <= ~rst_cnt;
            end
            if (state_q == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (capture) begin
                cap_q <= puf_resp;
                idx   <= '0;
                acc   <= '0;
            end
            if (expire) begin
                hd      <= HD_TIMEOUT;
                timeout <= 1'b1;
                pass    <= 1'b0;
                cap_q   <= '0;
                ref_q   <= '0;
            end
            if (state_q == COMPARE) begin
                acc   <= acc + 8'(pc);
                cap_q <= cap_q << CHUNK_W;
                ref_q <= ref_q << CHUNK_W;
                idx   <= idx + IDX_W'(1);
            end
            // Secrets are wiped as the run finishes.
            if (state_q == DECIDE) begin
                hd    <= acc;
                pass  <= (acc <= thr_q);
                cap_q <= '0;
                ref_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_puf_auth_verifier.sv
// Scoreboard bench for puf_auth_verifier: golden results queued at start, checked at done.
module tb_puf_auth_verifier;

    localparam int TO = 1023;
    localparam logic [127:0] REF = 128'h5468697349734E6F74576F726B696E67;

    typedef struct {
        logic [7:0] hd;
        logic       pass;
        logic       to;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] ref_resp = '0;
    logic [7:0]   threshold = '0;
    logic [127:0] puf_resp = '0;
    logic         puf_done = 1'b0;
    logic         puf_rst;
    logic         busy;
    logic         done;
    logic         pass;
    logic         timeout;
    logic [7:0]   hd;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    puf_auth_verifier dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_resp  (ref_resp),
        .threshold (threshold),
        .puf_resp  (puf_resp),
        .puf_done  (puf_done),
        .puf_rst   (puf_rst),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .hd        (hd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_result();
        exp_t e;
        e = sb.pop_front();
        chk("hd", 32'(hd), 32'(e.hd));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("timeout", 32'(timeout), 32'(e.to));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("puf_rst_at_done", 32'(puf_rst), 32'd1);
    endtask

    // dly: cycles after the first WAIT cycle before puf_done rises (0 = already high).
    task automatic run(input logic [127:0] r, input logic [127:0] p, input logic [7:0] t,
                       input int dly, input bit pre, input bit drop);
        exp_t e;
        int   n;
        int   lat;
        int   want;
        n = $countones(r ^ p);
        e.hd   = 8'(n);
        e.pass = (n <= int'(t));
        e.to   = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        ref_resp  = r;
        threshold = t;
        start     = 1'b1;
        puf_done  = pre;
        puf_resp  = pre ? p : '0;
        @(negedge clk);
        start     = 1'b0;
        ref_resp  = {$urandom, $urandom, $urandom, $urandom};
        threshold = 8'($urandom);
        n = 0;
        while (puf_rst === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("restart_len", 32'(n), 32'd2);
        lat = 0;
        repeat (dly) begin
            @(negedge clk);
            lat++;
        end
        puf_done = 1'b1;
        puf_resp = p;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (drop && dly > 0 && lat == dly + 1) begin
                puf_done = 1'b0;
                puf_resp = ~p;
            end
            if (done === 1'b1) break;
        end
        want = (dly == 0) ? 12 : dly + 11;
        chk("latency", 32'(lat), 32'(want));
        check_result();
        puf_done = 1'b0;
    endtask

    initial begin
        exp_t         e;
        int           n;
        int           lat;
        logic [127:0] r;
        logic [127:0] p;

        repeat (3) @(negedge clk);
        chk("rst_puf_rst", 32'(puf_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_hd", 32'(hd), 32'd0);
        rst = 1'b0;

        run(REF, REF, 8'd0, 3, 1'b0, 1'b1);
        run(REF, REF ^ 128'h000F_0000_0000_0000_0000_0000_0000_0101, 8'd5, 1, 1'b0, 1'b1);
        run(REF, REF ^ 128'h000F_0000_0000_0000_0000_0000_0000_0101, 8'd6, 2, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(done), 32'd1);
        chk("hd_hold", 32'(hd), 32'd6);
        run(REF, ~REF, 8'd200, 1, 1'b0, 1'b1);
        run(REF, REF ^ 128'h1, 8'd0, 2, 1'b0, 1'b0);
        run(REF, REF, 8'd0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            p = r ^ ({$urandom, $urandom, $urandom, $urandom}
                   & {$urandom, $urandom, $urandom, $urandom}
                   & {$urandom, $urandom, $urandom, $urandom});
            run(r, p, 8'($urandom_range(0, 40)), $urandom_range(1, 4), 1'b0, k[0]);
        end

        // Generator never finishes: start edge, two RESTART cycles, TO WAIT cycles, DONE entry.
        e.hd = 8'hFF;
        e.pass = 1'b0;
        e.to = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        ref_resp  = REF;
        threshold = 8'd200;
        start     = 1'b1;
        lat = 0;
        while (lat < 1200) begin
            @(posedge clk);
            lat++;
            #1;
            start = 1'b0;
            if (done === 1'b1) break;
        end
        chk("timeout_latency", 32'(lat), 32'(TO + 4));
        check_result();

        // Start mid-COMPARE is ignored; reset on the 4th COMPARE cycle aborts the run.
        @(negedge clk);
        ref_resp  = REF;
        threshold = 8'd10;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (puf_rst === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        puf_done = 1'b1;
        puf_resp = REF ^ 128'h1;
        @(posedge clk);
        #1 puf_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", 32'(busy), 32'd1);
        chk("ignored_start_puf_rst", 32'(puf_rst), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_puf_rst", 32'(puf_rst), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_timeout", 32'(timeout), 32'd0);
        chk("abort_hd", 32'(hd), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_stays_idle", 32'(done), 32'd0);
        chk("abort_idle_puf_rst", 32'(puf_rst), 32'd1);
        run(REF, REF ^ 128'h8000_0000_0000_0000_0000_0000_0000_0003, 8'd3, 2, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/puf_auth_verifier.md
PUF_AUTH_VERIFIER -- requirements
Module: puf_auth_verifier

Interface
REQ-001 SHALL have parameter CHUNK_W, default 16; bits compared per cycle; must divide 128.
REQ-002 SHALL have parameter TIMEOUT, default 1023; max cycles to wait for generator completion.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin one authentication.
REQ-006 ref_resp  input  128  enrolled golden response; sampled on accepted start.
REQ-007 threshold  input  8  max allowed Hamming distance; sampled on accepted start.
REQ-008 puf_resp  input  128  response word from 128-bit PUF generator.
REQ-009 puf_done  input  1  generator level flag: puf_resp valid.
REQ-010 puf_rst  output  1  synchronous reset to generator; high = generator held/cleared.
REQ-011 busy  output  1  high from accepted start until done.
REQ-012 done  output  1  level; high in DONE until next accepted start or rst.
REQ-013 pass  output  1  valid when done; 1 = hd <= threshold and no timeout.
REQ-014 timeout  output  1  valid when done; 1 = generator did not finish in TIMEOUT cycles.
REQ-015 hd  output  8  Hamming distance result; 8'hFF on timeout.

Function
REQ-016 FSM states SHALL be IDLE, RESTART, WAIT, COMPARE, DECIDE, DONE.
REQ-017 start SHALL be accepted only in IDLE or DONE; ignored in every other state.
REQ-018 Accepted start: latch ref_resp/threshold, clear done/pass/timeout/hd, busy=1, go RESTART.
REQ-019 RESTART SHALL hold puf_rst=1 exactly 2 cycles, then enter WAIT with puf_rst=0.
REQ-020 WAIT SHALL ignore puf_done during its first cycle (stale flag guard).
REQ-021 WAIT, puf_done sampled high: capture puf_resp, chunk index=0, accumulator=0, go COMPARE.
REQ-022 WAIT SHALL count cycles; on reaching TIMEOUT: hd=8'hFF, timeout=1, pass=0, go DONE.
REQ-023 COMPARE SHALL take exactly 128/CHUNK_W cycles (8 at default), MSB chunk [127:112] first.
REQ-024 Each COMPARE cycle SHALL add popcount(captured chunk XOR ref chunk) to 8-bit accumulator; max 128, no overflow.
REQ-025 After last chunk: hd=accumulator, go DECIDE.
REQ-026 DECIDE (1 cycle): pass=(hd <= threshold), unsigned compare; done=1, busy=0, go DONE.
REQ-027 Latency: done high 10 rising edges after the edge sampling puf_done in WAIT (default CHUNK_W).
REQ-028 Entering DONE SHALL zero the captured-response and latched-reference registers and drive puf_rst=1.
REQ-029 threshold=0 passes only on exact match; threshold>=128 passes any non-timeout run.
REQ-030 puf_done deasserting during COMPARE SHALL NOT affect result (captured copy used).

Reset
REQ-031 rst SHALL override all states, including mid-COMPARE, returning to IDLE next edge.
REQ-032 Reset values: puf_rst=1, busy=0, done=0, pass=0, timeout=0, hd=0, all internal registers and counters 0.
REQ-033 puf_rst SHALL remain 1 in IDLE, RESTART and DONE.

Structure
REQ-034 Package puf_auth_pkg SHALL hold state enum, CHUNK_W default, NUM_CHUNKS, TIMEOUT default, HD_TIMEOUT=8'hFF.
REQ-035 One sub-module popcount_chunk (combinational, CHUNK_W in, clog2(CHUNK_W)+1 out) SHALL compute per-chunk popcount.

Verification
REQ-036 Exact match: ref=puf_resp=128'h5468697349734E6F74576F726B696E67, thr=0 -> hd=0, pass=1, timeout=0, done 10 edges after puf_done.
REQ-037 Distance: puf_resp=ref XOR 128'h000F_0000_0000_0000_0000_0000_0000_0101, thr=5 -> hd=6, pass=0; same stimulus with thr=6 -> pass=1.
REQ-038 Full inversion: puf_resp=~ref, thr=200 -> hd=128 (8'h80), pass=1.
REQ-039 Timeout: puf_done held 0, TIMEOUT=1023 -> done after RESTART+1023 WAIT cycles, hd=8'hFF, timeout=1, pass=0, puf_rst=1.
REQ-040 Stale flag: puf_done=1 constantly from start -> puf_rst high 2 cycles, first WAIT cycle ignored, capture on second WAIT cycle.
REQ-041 Control: start pulsed in COMPARE -> ignored; rst at 4th COMPARE cycle -> IDLE, all outputs at reset values; new start then completes normally.
